// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared I2S frame constants, channel encoding and divider helper.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_channel_e;

    // Half-period of the serial clock measured in system clocks.
    function automatic int calc_half_div(input int clk_freq, input int sck_freq);
        return clk_freq / (2 * sck_freq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchroniser for signals asynchronous to clk.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/i2s_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_capture
// Description : I2S master receiver; generates sck/ws, captures one channel.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_capture
    import i2s_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int SCK_FREQ  = 3_125_000,
    parameter int DATA_SIZE = 24,
    parameter int CHANNEL   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 i2s_clk,
    output logic                 i2s_ws,
    input  logic                 i2s_sd,
    output logic [DATA_SIZE-1:0] sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic [15:0]          overrun_count
);

    localparam int HALF_DIV = calc_half_div(CLK_FREQ, SCK_FREQ);
    localparam int DIV_W    = $clog2(HALF_DIV);
    localparam int OVR_W    = 16;

    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(HALF_DIV - 1);
    localparam i2s_channel_e         CH_SEL    = i2s_channel_e'(CHANNEL[0]);
    localparam int                   CH_OFF    = (CH_SEL == CH_RIGHT) ? SLOT_BITS : 0;
    localparam logic [BIT_CNT_W-1:0] FIRST_BIT = BIT_CNT_W'(CH_OFF + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(CH_OFF + DATA_SIZE);
    localparam logic [BIT_CNT_W-1:0] WS_HIGH   = BIT_CNT_W'(SLOT_BITS);
    localparam logic [OVR_W-1:0]     OVR_MAX   = {OVR_W{1'b1}};

    if (HALF_DIV < 4) begin : g_err_half_div
        $error("i2s_rx_capture: CLK_FREQ/(2*SCK_FREQ) must be at least 4");
    end
    if ((CLK_FREQ % (2 * SCK_FREQ)) != 0) begin : g_err_div_exact
        $error("i2s_rx_capture: CLK_FREQ must be divisible by 2*SCK_FREQ");
    end
    if ((DATA_SIZE < 1) || (DATA_SIZE > 31)) begin : g_err_data_size
        $error("i2s_rx_capture: DATA_SIZE must be in 1..31");
    end
    if ((CHANNEL < 0) || (CHANNEL > 1)) begin : g_err_channel
        $error("i2s_rx_capture: CHANNEL must be 0 or 1");
    end

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 sck_q, sck_d;
    logic                 ws_q, ws_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 done_q, done_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic [OVR_W-1:0]     ovr_q, ovr_d;

    logic sd_sync;
    logic div_wrap;
    logic fall_tick;
    logic in_window;
    logic xfer;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_sd_sync (
        .clk (clk),
        .rst (rst),
        .d_i (i2s_sd),
        .q_o (sd_sync)
    );

    assign div_wrap  = (div_cnt_q == DIV_LAST);
    assign fall_tick = div_wrap & sck_q;
    assign in_window = (bit_cnt_q >= FIRST_BIT) && (bit_cnt_q <= LAST_BIT);
    assign xfer      = valid_q & sample_ready;

    // Serial clock, frame position and shifter; all of it collapses while en is low.
    always_comb begin
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        ws_d      = ws_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        if (!en) begin
            div_cnt_d = '0;
            sck_d     = 1'b0;
            ws_d      = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
            if (div_wrap) begin
                sck_d = ~sck_q;
            end
            if (fall_tick) begin
                // Counter width matches the frame, so 63 wraps to 0 naturally.
                bit_cnt_d = bit_cnt_q + 1'b1;
                ws_d      = (bit_cnt_d >= WS_HIGH);
                if (in_window) begin
                    shift_d = DATA_SIZE'({shift_q, sd_sync});
                end
                done_d = (bit_cnt_q == LAST_BIT);
            end
        end
    end

    // Output holding register: a completed word loads only into a free or draining slot.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (xfer) begin
            valid_d = 1'b0;
        end
        if (done_q) begin
            if (!valid_q || xfer) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else if (ovr_q != OVR_MAX) begin
                ovr_d = ovr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign i2s_clk       = sck_q;
    assign i2s_ws        = ws_q;
    assign sample_data   = data_q;
    assign sample_valid  = valid_q;
    assign overrun_count = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_rx_capture
// Description : Directed bench: left/right capture DUTs fed by an I2S mic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_capture;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          i2s_sd = 1'b0;
    logic          ready_base = 1'b0;
    logic          ready_pulse = 1'b0;
    logic          ready_l;
    logic          sck_l, ws_l, valid_l;
    logic [DW-1:0] data_l;
    logic [15:0]   ovr_l;
    logic          sck_r, ws_r, valid_r;
    logic [DW-1:0] data_r;
    logic [15:0]   ovr_r;

    assign ready_l = ready_base | ready_pulse;

    always #5 clk = ~clk;

    i2s_rx_capture #(.CLK_FREQ(50_000_000), .SCK_FREQ(3_125_000), .DATA_SIZE(DW), .CHANNEL(0)) dut_l (
        .clk(clk), .rst(rst), .en(en), .i2s_clk(sck_l), .i2s_ws(ws_l), .i2s_sd(i2s_sd),
        .sample_data(data_l), .sample_valid(valid_l), .sample_ready(ready_l), .overrun_count(ovr_l));

    i2s_rx_capture #(.CLK_FREQ(50_000_000), .SCK_FREQ(3_125_000), .DATA_SIZE(DW), .CHANNEL(1)) dut_r (
        .clk(clk), .rst(rst), .en(en), .i2s_clk(sck_r), .i2s_ws(ws_r), .i2s_sd(i2s_sd),
        .sample_data(data_r), .sample_valid(valid_r), .sample_ready(1'b1), .overrun_count(ovr_r));

    int checks = 0;
    int failures = 0;

    // Mic model / monitor state (written only by the negedge process below)
    int            p = 0;
    int            frames = 0;
    int            cyc = 0;
    int            fall24 = -100;
    int            fall56 = -100;
    int            last_fall = -1;
    int            sck_err = 0;
    int            ws_err = 0;
    int            lat_err = 0;
    int            xfer_cnt = 0;
    logic [DW-1:0] cur_l = '0, cur_r = '0;
    logic          sck_prev = 1'b0, vprev_l = 1'b0, vprev_r = 1'b0, rdy;
    // Written only by the stimulus process
    logic [DW-1:0] next_l = '0, next_r = '0;
    logic          pulse_arm = 1'b0;

    // Standard I2S transmitter: MSB one sck period after the ws change, zeros after LSB.
    function automatic logic mic_bit(input int k, input logic [DW-1:0] wl, input logic [DW-1:0] wr);
        if (k >= 1 && k <= DW)       return wl[DW-k];
        if (k >= 33 && k <= 32 + DW) return wr[32+DW-k];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (ready_pulse) ready_pulse = 1'b0;
        if (rst || !en) begin
            p = 0;
            cur_l = next_l;
            cur_r = next_r;
            last_fall = -1;
        end else begin
            if (sck_prev && !sck_l) begin
                if (last_fall >= 0 && (cyc - last_fall) != 16) sck_err++;
                last_fall = cyc;
                if (p == 24) fall24 = cyc;
                if (p == 56) fall56 = cyc;
                p = (p + 1) % 64;
                if (p == 0) begin
                    frames++;
                    cur_l = next_l;
                    cur_r = next_r;
                end
                if (p == 25 && pulse_arm) ready_pulse = 1'b1;
            end
            if (ws_l !== (p >= 32) || ws_r !== (p >= 32)) ws_err++;
        end
        rdy = ready_base | ready_pulse;
        if (valid_l && rdy) xfer_cnt++;
        // valid must rise one clk after the sck fall that ends the last data period
        if (valid_l && !vprev_l && (cyc - fall24) != 1) lat_err++;
        if (valid_r && !vprev_r && (cyc - fall56) != 1) lat_err++;
        vprev_l = valid_l;
        vprev_r = valid_r;
        sck_prev = sck_l;
        i2s_sd = mic_bit(p, cur_l, cur_r);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame_start();
        int f0 = frames;
        int n = 0;
        while (frames == f0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", 32'(frames != f0), 32'd1);
    endtask

    task automatic wait_bit(input int k, input logic need_sck);
        int n = 0;
        while (!(p == k && (!need_sck || sck_l)) && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_bit_%0d", k), 32'(n < 1200), 32'd1);
    endtask

    typedef struct {
        logic [DW-1:0] wl;
        logic [DW-1:0] wr;
        logic          rdy;
        logic          pulse;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [15:0]   exp_ovr;
        int            exp_xfer;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, x0, highs;
        //           left       right      rdy   pulse vld   data       ovr    xfers
        tbl[0] = '{24'hA5C3E1, 24'h123456, 1'b1, 1'b0, 1'b0, 24'hA5C3E1, 16'd0, 1};
        tbl[1] = '{24'h5A3C1E, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 24'h5A3C1E, 16'd0, 1};
        tbl[2] = '{24'h800001, 24'h7FFFFE, 1'b0, 1'b0, 1'b1, 24'h800001, 16'd0, 0};
        tbl[3] = '{24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h800001, 16'd1, 0};
        tbl[4] = '{24'h000000, 24'hFEDCBA, 1'b0, 1'b0, 1'b1, 24'h800001, 16'd2, 0};
        tbl[5] = '{24'hC0FFEE, 24'h654321, 1'b1, 1'b0, 1'b0, 24'hC0FFEE, 16'd2, 2};
        tbl[6] = '{24'h111111, 24'h999999, 1'b0, 1'b0, 1'b1, 24'h111111, 16'd2, 0};
        tbl[7] = '{24'h222222, 24'hAAAAAA, 1'b0, 1'b1, 1'b1, 24'h222222, 16'd2, 1};
        tbl[8] = '{24'h333333, 24'h555555, 1'b1, 1'b0, 1'b0, 24'h333333, 16'd2, 2};

        // Reset
        next_l = tbl[0].wl;
        next_r = tbl[0].wr;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sck", 32'(sck_l), 32'd0);
        chk("rst_ws", 32'(ws_l), 32'd0);
        chk("rst_valid", 32'(valid_l | valid_r), 32'd0);
        chk("rst_data", 32'(data_l | data_r), 32'd0);
        chk("rst_ovr", 32'(ovr_l | ovr_r), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_sck", 32'(sck_l), 32'd0);

        // Enable: first rise HALF_DIV=8 clocks later, fall 8 clocks after that
        ready_base = tbl[0].rdy;
        pulse_arm  = tbl[0].pulse;
        en = 1'b1;
        n = 0;
        while (!sck_l && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_rise_cycles", 32'(n), 32'd8);
        n = 0;
        while (sck_l && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sck_high_cycles", 32'(n), 32'd8);
        chk("ws_low_period0", 32'(ws_l), 32'd0);

        // Frame-by-frame table: ready pattern, expected holding-register state at frame end
        for (int i = 0; i < 9; i++) begin
            ready_base = tbl[i].rdy;
            pulse_arm  = tbl[i].pulse;
            x0 = xfer_cnt;
            if (i < 8) begin
                next_l = tbl[i+1].wl;
                next_r = tbl[i+1].wr;
            end
            wait_frame_start();
            chk($sformatf("f%0d_valid_l", i), 32'(valid_l), 32'(tbl[i].exp_valid));
            chk($sformatf("f%0d_data_l", i), 32'(data_l), 32'(tbl[i].exp_data));
            chk($sformatf("f%0d_ovr_l", i), 32'(ovr_l), 32'(tbl[i].exp_ovr));
            chk($sformatf("f%0d_xfers_l", i), 32'(xfer_cnt - x0), 32'(tbl[i].exp_xfer));
            chk($sformatf("f%0d_data_r", i), 32'(data_r), 32'(tbl[i].wr));
            chk($sformatf("f%0d_valid_r", i), 32'(valid_r), 32'd0);
            @(posedge clk);
            #1;
        end
        pulse_arm = 1'b0;

        // Enable abort at bit 10 while sck is high, 40 cycles low, then restart
        ready_base = 1'b1;
        next_l = 24'h0F1E2D;
        next_r = 24'h3C4B5A;
        wait_bit(10, 1'b1);
        @(posedge clk);
        #1;
        en = 1'b0;
        x0 = xfer_cnt;
        @(posedge clk);
        #1;
        chk("abort_sck_low", 32'(sck_l), 32'd0);
        chk("abort_ws_low", 32'(ws_l | ws_r), 32'd0);
        highs = 0;
        repeat (39) begin
            @(posedge clk);
            #1;
            if (sck_l) highs++;
        end
        chk("abort_sck_idle", 32'(highs), 32'd0);
        chk("abort_no_sample", 32'(xfer_cnt - x0), 32'd0);
        en = 1'b1;
        wait_frame_start();
        chk("restart_xfers_l", 32'(xfer_cnt - x0), 32'd1);
        chk("restart_data_l", 32'(data_l), 32'h0F1E2D);
        chk("restart_data_r", 32'(data_r), 32'h3C4B5A);

        // Reset mid-frame drops a pending sample and the overrun count
        @(posedge clk);
        #1;
        ready_base = 1'b0;
        wait_bit(30, 1'b0);
        chk("pre_rst_valid", 32'(valid_l), 32'd1);
        chk("pre_rst_ovr", 32'(ovr_l), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(valid_l), 32'd0);
        chk("midrst_data", 32'(data_l), 32'd0);
        chk("midrst_ovr", 32'(ovr_l), 32'd0);
        chk("midrst_sck_ws", 32'({sck_l, ws_l}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("ws_tracks_frame", 32'(ws_err), 32'd0);
        chk("sck_period_16", 32'(sck_err), 32'd0);
        chk("valid_latency", 32'(lat_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_rx_capture.md
Name: i2s_rx_capture

Overview:
- I2S master receiver that generates i2s_clk and i2s_ws for an I2S MEMS microphone and deserialises i2s_sd into DATA_SIZE-bit two's-complement samples from one selected channel.
- Presents each sample on a valid/ready interface that feeds the sample-reduction / FIFO stage, which is drained over SPI.
- Sits directly upstream of the capture FIFO inside i2s_fpga.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency, Hz.
- SCK_FREQ, 3_125_000: target i2s_clk frequency, Hz.
  - localparam HALF_DIV = CLK_FREQ/(2*SCK_FREQ).
  - Elaboration error if HALF_DIV < 4 or CLK_FREQ is not divisible by 2*SCK_FREQ.
- DATA_SIZE, 24: captured bits per sample, MSB first. Range 1..31.
- CHANNEL, 0: channel to capture. 0 = left (ws low), 1 = right (ws high).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- en  in  1  capture enable.
- i2s_clk  out  1  serial clock to microphone.
- i2s_ws  out  1  word select.
- i2s_sd  in  1  serial data, asynchronous to clk.
- sample_data  out  DATA_SIZE  captured sample.
- sample_valid  out  1  sample available.
- sample_ready  in  1  downstream accepts sample.
- overrun_count  out  16  samples dropped due to backpressure, saturating.

Behaviour:
- Reset values: i2s_clk=0, i2s_ws=0, sample_data=0, sample_valid=0, overrun_count=0. Internal div_cnt=0, bit_cnt=0, shift register=0.
- Clock generation:
  - div_cnt counts 0..HALF_DIV-1 while en=1.
  - On the cycle div_cnt==HALF_DIV-1, i2s_clk toggles and div_cnt wraps to 0.
  - Period is 2*HALF_DIV clk cycles, 50% duty cycle.
- Frame structure: 64 sck periods, bit_cnt 0..63, wrapping 63->0.
  - Period k runs from one falling edge of i2s_clk to the next.
  - On each falling-edge tick, bit_cnt <= bit_cnt+1 and i2s_ws <= (bit_cnt+1 >= 32). ws therefore changes only on falling edges: low for periods 0..31, high for 32..63.
- Data capture:
  - i2s_sd passes through a 2-flop synchroniser.
  - On the falling-edge tick that ends period k, the synchronised sd is the bit for period k.
  - CH_OFF = 32*CHANNEL.
  - Bits for k in [CH_OFF+1, CH_OFF+DATA_SIZE] shift into the shift register MSB first (standard I2S 1-bit delay). All other bits are ignored.
- Completion: when the tick captures bit k = CH_OFF+DATA_SIZE, the sample is complete. On the next clk cycle:
  - If sample_valid==0, or sample_valid & sample_ready in the completion cycle: sample_data <= shift value, sample_valid <= 1.
  - Otherwise the new sample is dropped, sample_data/sample_valid are unchanged, and overrun_count increments (saturates at 16'hFFFF).
- Handshake:
  - Transfer occurs when sample_valid & sample_ready.
  - sample_valid clears the cycle after a transfer unless a new sample loads in that same cycle.
  - sample_data is stable while sample_valid=1 and not accepted.
- en deasserted:
  - The next cycle forces i2s_clk=0 and i2s_ws=0, and resets div_cnt, bit_cnt and the shift register.
  - The partial sample is discarded and no sample_valid results from it.
  - An already-pending sample_valid is kept until accepted.
- en re-asserted: the frame restarts at bit_cnt=0. The first rising edge of i2s_clk occurs HALF_DIV cycles later.
- rst mid-frame: all state returns to reset values on that clock edge. A pending sample is lost.

Decomposition:
- Package i2s_pkg:
  - SLOT_BITS=32, FRAME_BITS=64.
  - Typedef i2s_channel_e {CH_LEFT=0, CH_RIGHT=1}.
  - Function to compute HALF_DIV.
- Sub-module sync_2ff: generic 2-flop synchroniser, used for i2s_sd.
- Clock divider, bit counter, shifter and output register live in this module.

Test Plan (CLK_FREQ=50e6, SCK_FREQ=3.125e6 → HALF_DIV=8, 16-clk sck period, 1024-clk frame):
- Reset and clocking: hold rst 5 cycles, then en=1 → all outputs 0 during reset; first i2s_clk rise 8 cycles after en sampled; ws low for 512 clk and high for 512 clk; ws edges coincide with i2s_clk falls.
- Left capture: mic model drives left word 24'hA5C3E1 and right word 24'h123456 with 1-bit delay, trailing zeros, CHANNEL=0, ready=1 → one sample_valid per frame with sample_data=24'hA5C3E1, asserted 1 cycle after the tick capturing bit 24.
- Right capture: same stimulus with CHANNEL=1 → sample_data=24'h123456, one per frame.
- Backpressure: ready=0 for 3 frames → first sample held stable and overrun_count=2; ready=1 → transfer; next frame delivers the fresh sample.
- Accept and load in the same cycle: ready pulsed exactly on the completion cycle while valid=1 → new data loads, valid stays 1, overrun_count unchanged.
- Enable abort: en=0 at bit_cnt=10 for 40 cycles, then en=1 → i2s_clk and ws low next cycle; no sample from the aborted frame; first complete frame after restart yields the correct value.
